// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM state encoding, default hold limit and the
// master-side request bundle used by the arbiter and its mux.
package bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam int unsigned MAX_HOLD_DEF = 8;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [63:0] dout;
  } bus_req_t;

endpackage

// File: rtl/bus_mux2.sv
// Combinational 2-master select onto the bus port plus read-data demux.
// Nothing reaches the bus unless its grant is high; with no grant the bus
// and both read-data returns are all zero.
module bus_mux2
  import bus_pkg::*;
(
  input  logic        gnt0,
  input  logic        gnt1,
  input  bus_req_t    m0,
  input  bus_req_t    m1,
  input  logic [63:0] m_din,
  output bus_req_t    bus,
  output logic [63:0] m0_din,
  output logic [63:0] m1_din
);

  // grant-gated select and demux; gnt0/gnt1 are one-hot or zero
  always_comb begin
    bus    = '0;
    m0_din = '0;
    m1_din = '0;
    if (gnt0) begin
      bus    = m0;
      m0_din = m_din;
    end else if (gnt1) begin
      bus    = m1;
      m1_din = m_din;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: M0 priority from idle, direct handover between
// masters, and a hold counter that forces a handover after MAX_HOLD cycles
// when the other master is waiting.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m0_dout,
  input  logic [63:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [63:0] m0_din,
  output logic [63:0] m1_din,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] hold_cnt;
  bus_req_t   bus;

  // next-state: idle priority, release/handover, forced handover on hold limit
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (m0_req)      state_nxt = ST_GNT0;
        else if (m1_req) state_nxt = ST_GNT1;
        else             state_nxt = ST_IDLE;
      end
      ST_GNT0: begin
        if (!m0_req)                           state_nxt = m1_req ? ST_GNT1 : ST_IDLE;
        else if (m1_req && hold_cnt == HOLD_LAST) state_nxt = ST_GNT1;
        else                                   state_nxt = ST_GNT0;
      end
      ST_GNT1: begin
        if (!m1_req)                           state_nxt = m0_req ? ST_GNT0 : ST_IDLE;
        else if (m0_req && hold_cnt == HOLD_LAST) state_nxt = ST_GNT0;
        else                                   state_nxt = ST_GNT1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state and hold counter; counter restarts on every state change
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        hold_cnt <= '0;
      else if ((state == ST_GNT0 || state == ST_GNT1) && hold_cnt < HOLD_LAST)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign m0_grant = (state == ST_GNT0);
  assign m1_grant = (state == ST_GNT1);

  bus_mux2 u_mux (
    .gnt0   (m0_grant),
    .gnt1   (m1_grant),
    .m0     ('{req: m0_req, wr: m0_wr, addr: m0_addr, dout: m0_dout}),
    .m1     ('{req: m1_req, wr: m1_wr, addr: m1_addr, dout: m1_dout}),
    .m_din  (m_din),
    .bus    (bus),
    .m0_din (m0_din),
    .m1_din (m1_din)
  );

  assign m_req  = bus.req;
  assign m_wr   = bus.wr;
  assign m_addr = bus.addr;
  assign m_dout = bus.dout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for the cycle-by-cycle
// behaviour, plus hand sequences for request-rise gating and hold-limit
// alternation.
module tb_bus_arbiter;

  localparam logic [15:0] A0  = 16'h00aa;
  localparam logic [15:0] A1  = 16'h0800;
  localparam logic [63:0] D0  = 64'h1111_0000_0000_1111;
  localparam logic [63:0] D1  = 64'h2222_0000_0000_2222;
  localparam logic [63:0] DF  = 64'h0000_000f_ffff_ffff;
  localparam logic [63:0] DIN = 64'habcdabcd_abcdabcd;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m1_req, m0_wr, m1_wr;
  logic [15:0] m0_addr, m1_addr, m_addr;
  logic [63:0] m0_dout, m1_dout, m_dout, m_din, m0_din, m1_din;
  logic        m0_grant, m1_grant, m_req, m_wr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m0_din(m0_din), .m1_din(m1_din),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
  );

  typedef struct {
    logic        rst, r0, r1, w1;
    logic [63:0] d1;
    logic        g0, g1, er, ew;
    logic [15:0] ea;
    logic [63:0] ed, e0, e1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, r0, r1, w1, input logic [63:0] d1,
                              input logic g0, g1, er, ew, input logic [15:0] ea,
                              input logic [63:0] ed, e0, e1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.w1 = w1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.er = er; v.ew = ew; v.ea = ea;
    v.ed = ed; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [211:0] act, input logic [211:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [211:0] outs();
    return {m0_grant, m1_grant, m_req, m_wr, m_addr, m_dout, m0_din, m1_din};
  endfunction

  initial begin
    reset_n = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = A0; m1_addr = A1; m0_dout = D0; m1_dout = D1; m_din = DIN;

    //          rst r0 r1 w1 d1     g0 g1 er ew ea  ed  e0   e1
    tbl.push_back(mk(1, 1, 1, 0, D1,  0, 0, 0, 0, 0,  0,  0,   0  )); // reset, both req
    tbl.push_back(mk(1, 1, 1, 0, D1,  0, 0, 0, 0, 0,  0,  0,   0  ));
    tbl.push_back(mk(0, 1, 1, 0, D1,  1, 0, 1, 0, A0, D0, DIN, 0  )); // simultaneous -> M0
    tbl.push_back(mk(0, 0, 1, 0, D1,  0, 1, 1, 0, A1, D1, 0,   DIN)); // handover, no bubble
    tbl.push_back(mk(0, 0, 1, 1, DF,  0, 1, 1, 1, A1, DF, 0,   DIN)); // M1 write
    tbl.push_back(mk(0, 0, 0, 0, D1,  0, 0, 0, 0, 0,  0,  0,   0  )); // release -> idle
    tbl.push_back(mk(0, 1, 0, 0, D1,  1, 0, 1, 0, A0, D0, DIN, 0  ));
    tbl.push_back(mk(0, 1, 1, 0, D1,  1, 0, 1, 0, A0, D0, DIN, 0  )); // M1 briefly requests
    tbl.push_back(mk(0, 1, 0, 0, D1,  1, 0, 1, 0, A0, D0, DIN, 0  )); // ...and drops
    tbl.push_back(mk(0, 0, 0, 0, D1,  0, 0, 0, 0, 0,  0,  0,   0  )); // dropped req forgotten
    tbl.push_back(mk(0, 0, 1, 0, D1,  0, 1, 1, 0, A1, D1, 0,   DIN)); // M1 alone
    tbl.push_back(mk(1, 0, 1, 0, D1,  0, 0, 0, 0, 0,  0,  0,   0  )); // mid-grant reset
    tbl.push_back(mk(0, 0, 1, 0, D1,  0, 1, 1, 0, A1, D1, 0,   DIN)); // regrant after release
    tbl.push_back(mk(0, 0, 0, 0, D1,  0, 0, 0, 0, 0,  0,  0,   0  ));

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n = tbl[i].rst; m0_req = tbl[i].r0; m1_req = tbl[i].r1;
      m1_wr = tbl[i].w1; m1_dout = tbl[i].d1;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].g0, tbl[i].g1, tbl[i].er, tbl[i].ew, tbl[i].ea,
             tbl[i].ed, tbl[i].e0, tbl[i].e1});
    end
    m1_wr = 1'b0; m1_dout = D1;

    // request rising while idle must not leak onto the bus before the grant
    @(negedge clk);
    m1_req = 1'b1; #1;
    check("rise_gate", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 64'h0, 64'h0});
    @(posedge clk); #1;
    check("rise_grant", outs(), {1'b0, 1'b1, 1'b1, 1'b0, A1, D1, 64'h0, DIN});
    m1_req = 1'b0;
    @(posedge clk); #1;
    check("rise_idle", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 64'h0, 64'h0});

    // both requesting continuously: 8 cycles each, alternating, M0 first
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 24; c++) begin
      logic e0g;
      e0g = ((c / 8) % 2) == 0;
      @(posedge clk); #1;
      check($sformatf("hold_c%0d", c), {210'h0, m0_grant, m1_grant}, {210'h0, e0g, ~e0g});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    check("hold_release", {210'h0, m0_grant, m1_grant}, 212'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles before a contested grant is forcibly handed over (legal range 2..255).
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous active-high reset, named per codebase port convention despite the suffix.
REQ-005 m0_req / m1_req  input  1 each  master bus request.
REQ-006 m0_wr / m1_wr  input  1 each  master write enable (1 = write, 0 = read).
REQ-007 m0_addr / m1_addr  input  16 each  master address.
REQ-008 m0_dout / m1_dout  input  64 each  master write data.
REQ-009 m0_grant / m1_grant  output  1 each  registered grant, at most one high.
REQ-010 m0_din / m1_din  output  64 each  read data returned to each master.
REQ-011 m_req, m_wr  output  1 each  muxed request/write to the BUS master port.
REQ-012 m_addr  output  16  muxed address; m_dout  output  64  muxed write data.
REQ-013 m_din  input  64  read data from the BUS master port.

Function
REQ-014 The FSM SHALL have states IDLE, GNT0, GNT1; m0_grant = (state==GNT0), m1_grant = (state==GNT1).
REQ-015 IDLE: m0_req -> GNT0; else m1_req -> GNT1; else stay (M0 wins simultaneous requests).
REQ-016 Arbitration latency SHALL be exactly one cycle: request sampled at edge N, grant high after edge N.
REQ-017 GNTx with mx_req low: other master requesting -> directly to the other GNT state (no IDLE bubble); otherwise -> IDLE.
REQ-018 GNTx with mx_req high: grant held while hold_cnt < MAX_HOLD-1, or while the other master is not requesting.
REQ-019 hold_cnt (8-bit) SHALL clear on every state change and increment each cycle in a GNT state, saturating at MAX_HOLD-1.
REQ-020 GNTx, mx_req high, hold_cnt == MAX_HOLD-1, other master requesting -> forced switch to the other GNT state.
REQ-021 Bus outputs (m_req, m_wr, m_addr, m_dout) SHALL combinationally follow the granted master's inputs; all zero in IDLE.
REQ-022 m_din SHALL route to the granted master's din; the non-granted din SHALL be 64'h0.
REQ-023 A master's inputs SHALL never reach the bus while its grant is low, including on the cycle its request first rises.
REQ-024 Requests that drop before being granted SHALL be discarded; the arbiter SHALL keep no pending-request memory.

Reset
REQ-025 With reset_n high at a clock edge: state = IDLE, hold_cnt = 0, both grants 0, all bus outputs and both din outputs 0.
REQ-026 Reset asserted mid-grant SHALL drop the grant at that edge; after release, arbitration restarts from IDLE with M0 priority.

Structure
REQ-027 State encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the default MAX_HOLD SHALL live in the shared bus package used by BUS.
REQ-028 One sub-module SHALL be used: bus_mux2, a purely combinational 2-master select for req/wr/addr/dout and din demux; FSM and counter stay in bus_arbiter.
REQ-029 Unused state encoding 2'd3 SHALL return to IDLE on the next edge.

Verification
REQ-030 Reset: reset_n=1 for 2 cycles with both reqs high -> grants 0, m_addr=16'h0000, m0_din=m1_din=0.
REQ-031 Simultaneous: m0_req=m1_req=1 from IDLE -> m0_grant=1 one cycle later; m_addr = m0_addr (16'h00aa), m1_din=0.
REQ-032 Handover: M0 granted, m0_req drops while m1_req=1 -> m1_grant=1 on the next edge, no IDLE cycle; m_addr = m1_addr (16'h0800).
REQ-033 Starvation guard: MAX_HOLD=8, both requesting continuously -> m0_grant high exactly 8 cycles, then m1_grant 8 cycles, alternating.
REQ-034 Read return: M1 granted, m_din=64'habcdabcd_abcdabcd -> m1_din equals it, m0_din=0; write with m1_wr=1, m1_dout=64'hfffffffff -> m_wr=1, m_dout=64'hfffffffff.
REQ-035 Mid-grant reset: reset_n=1 while in GNT1 -> m1_grant=0 and m_req=0 after that edge; then m1_req alone -> GNT1 one cycle after release.
